copperv_fetch: RTL and testbench

COPPERV_FETCH -- requirements
Module: copperv_fetch

---
 rtl/copperv_pkg.sv | 6 +
 rtl/copperv_fetch_if.sv | 31 +++
 rtl/copperv_fifo.sv | 62 ++++++
 rtl/copperv_fetch.sv | 119 +++++++++++
 tb/tb_copperv_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/copperv_pkg.sv
// Shared constants for the copperv instruction fetch slice.
package copperv_pkg;
    localparam int BUS_WIDTH = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/copperv_fetch_if.sv
// Memory read channels plus core-side instruction and redirect signals.
interface copperv_fetch_if #(
    parameter int bus_width = copperv_pkg::BUS_WIDTH
);
    logic                 i_raddr_valid;
    logic                 i_raddr_ready;
    logic [bus_width-1:0] i_raddr;
    logic                 i_rdata_valid;
    logic                 i_rdata_ready;
    logic [bus_width-1:0] i_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [bus_width-1:0] instr;
    logic [bus_width-1:0] instr_pc;
    logic                 jump;
    logic [bus_width-1:0] jump_target;

    modport master (
        output i_raddr_valid, i_raddr, i_rdata_ready,
        output instr_valid, instr, instr_pc,
        input  i_raddr_ready, i_rdata_valid, i_rdata,
        input  instr_ready, jump, jump_target
    );

    modport slave (
        input  i_raddr_valid, i_raddr, i_rdata_ready,
        input  instr_valid, instr, instr_pc,
        output i_raddr_ready, i_rdata_valid, i_rdata,
        output instr_ready, jump, jump_target
    );
endinterface

// File: rtl/copperv_fifo.sv
// Synchronous FIFO with flush; read and write may coincide even when full.
module copperv_fifo #(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [width-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [width-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = count_q == '0;
    assign full    = count_q == (AW+1)'(depth);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/copperv_fetch.sv
// Prefetching instruction fetch unit with credit-based request issue
// and in-order discard of responses made stale by a redirect.
module copperv_fetch
    import copperv_pkg::*;
#(
    parameter int bus_width = BUS_WIDTH,
    parameter int fifo_depth = 4,
    parameter logic [bus_width-1:0] reset_vector = bus_width'(RESET_VECTOR)
) (
    input logic             clk,
    input logic             rst,
    copperv_fetch_if.master bus
);
    localparam int CW = $clog2(fifo_depth + 1);
    localparam int QW = $clog2(fifo_depth) + 1;
    localparam int SW = CW + 2;
    localparam logic [SW-1:0] DEPTH = SW'(fifo_depth);
    localparam logic [SW-1:0] CNT_MAX = SW'((1 << CW) - 1);
    localparam logic [bus_width-1:0] STEP = bus_width'(bus_width / 8);

    logic [bus_width-1:0] fetch_pc_q, fetch_pc_d;
    logic [bus_width-1:0] hold_pc_q, hold_pc_d;
    logic [bus_width-1:0] resp_pc_q, resp_pc_d;
    logic                 raddr_valid_q, raddr_valid_d;
    logic                 stale_q, stale_d;
    logic [CW-1:0]        out_q, out_d;
    logic [CW-1:0]        disc_q, disc_d;

    logic                 addr_hs, data_hs, rd_en, wr_en;
    logic                 drop, live, credit;
    logic                 fifo_full, fifo_empty;
    logic [QW-1:0]        fifo_count;
    logic [2*bus_width-1:0] fifo_rdata;
    logic [SW-1:0]        out_sum, disc_sum, occ_sum;

    assign bus.i_raddr_valid = raddr_valid_q & ~rst;
    assign bus.i_raddr       = stale_q ? hold_pc_q : fetch_pc_q;
    assign bus.i_rdata_ready = ~rst;
    assign bus.instr_valid   = ~fifo_empty & ~rst;
    assign bus.instr_pc      = fifo_rdata[2*bus_width-1:bus_width];
    assign bus.instr         = fifo_rdata[bus_width-1:0];

    copperv_fifo #(
        .width(2 * bus_width),
        .depth(fifo_depth)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (bus.jump),
        .wr_en  (wr_en),
        .wr_data({resp_pc_q, bus.i_rdata}),
        .rd_en  (rd_en),
        .rd_data(fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_comb begin
        addr_hs = bus.i_raddr_valid & bus.i_raddr_ready;
        data_hs = bus.i_rdata_valid & bus.i_rdata_ready;
        rd_en   = bus.instr_valid & bus.instr_ready;
        drop    = disc_q != '0;
        live    = data_hs & ~drop & (out_q != '0);
        wr_en   = live & ~bus.jump & (~fifo_full | rd_en);

        out_sum  = SW'(out_q) + SW'(addr_hs & ~stale_q) - SW'(live);
        disc_sum = SW'(disc_q) + SW'(addr_hs & stale_q) - SW'(data_hs & drop);
        occ_sum  = SW'(fifo_count) + SW'(wr_en) - SW'(rd_en);
        // Redirect: everything still in flight is now owed a discard.
        if (bus.jump) begin
            disc_sum = disc_sum + out_sum;
            out_sum  = '0;
            occ_sum  = '0;
        end
        credit = (occ_sum + out_sum < DEPTH) &
                 (out_sum + disc_sum < CNT_MAX);
        out_d  = CW'(out_sum);
        disc_d = CW'(disc_sum);

        fetch_pc_d = fetch_pc_q;
        hold_pc_d  = hold_pc_q;
        resp_pc_d  = resp_pc_q;
        stale_d    = stale_q;
        if (addr_hs & ~stale_q) fetch_pc_d = fetch_pc_q + STEP;
        if (addr_hs) stale_d = 1'b0;
        if (wr_en) resp_pc_d = resp_pc_q + STEP;
        if (bus.jump) begin
            fetch_pc_d = bus.jump_target;
            resp_pc_d  = bus.jump_target;
            if (bus.i_raddr_valid & ~addr_hs & ~stale_q) begin
                stale_d   = 1'b1;
                hold_pc_d = fetch_pc_q;
            end
        end
        raddr_valid_d = (raddr_valid_q & ~addr_hs) | credit;
    end

    // Request is pre-armed in reset so it appears on the first free cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= reset_vector;
            hold_pc_q     <= reset_vector;
            resp_pc_q     <= reset_vector;
            raddr_valid_q <= 1'b1;
            stale_q       <= 1'b0;
            out_q         <= '0;
            disc_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            hold_pc_q     <= hold_pc_d;
            resp_pc_q     <= resp_pc_d;
            raddr_valid_q <= raddr_valid_d;
            stale_q       <= stale_d;
            out_q         <= out_d;
            disc_q        <= disc_d;
        end
    end
endmodule

// File: tb/tb_copperv_fetch.sv
// Bench for copperv_fetch: cycle tables, redirect/reset sequences,
// and a randomized memory/core against an expected instruction stream.
module tb_copperv_fetch;
    import copperv_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic        rst, ar, rv;
        logic [31:0] rpc;
        logic        ir, jmp;
        logic [31:0] tgt;
        logic        av;
        logic [31:0] aa;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t v;
    logic [31:0] memq[$];
    logic [31:0] exp_pc, held_addr, tgt;
    logic ar, rv, ir, jmp, a_hs, held, tb_stale;
    int live, consumed;

    copperv_fetch_if bus ();

    copperv_fetch dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic void add(
        logic r, logic a_r, logic r_v, logic [31:0] r_pc,
        logic i_r, logic j, logic [31:0] t,
        logic e_av, logic [31:0] e_aa, logic e_iv, logic [31:0] e_pc);
        vec_t n;
        n.rst = r; n.ar = a_r; n.rv = r_v; n.rpc = r_pc;
        n.ir = i_r; n.jmp = j; n.tgt = t;
        n.av = e_av; n.aa = e_aa; n.iv = e_iv; n.ipc = e_pc;
        vecs.push_back(n);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(logic r, logic a_r, logic r_v, logic [31:0] r_pc,
                         logic i_r, logic j, logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r;
        bus.i_raddr_ready = a_r;
        bus.i_rdata_valid = r_v;
        bus.i_rdata       = word_at(r_pc);
        bus.instr_ready   = i_r;
        bus.jump          = j;
        bus.jump_target   = t;
        @(negedge clk);
    endtask

    task automatic chk_instr(string name, logic [31:0] pc);
        chk({name, "_iv"}, bus.instr_valid, 1);
        chk({name, "_pc"}, bus.instr_pc, pc);
        chk({name, "_word"}, bus.instr, word_at(pc));
    endtask

    initial begin
        bus.i_raddr_ready = 0;
        bus.i_rdata_valid = 0;
        bus.i_rdata = '0;
        bus.instr_ready = 0;
        bus.jump = 0;
        bus.jump_target = '0;

        // Straight-line fetch, then back-pressure until one consume.
        add(1,0,0,0,0,0,0, 0,0,0,0);
        add(1,0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0,0, 1,'h0,0,0);
        add(0,1,1,'h0,0,0,0, 1,'h4,0,0);
        add(0,1,1,'h4,0,0,0, 1,'h8,1,'h0);
        add(0,1,1,'h8,0,0,0, 1,'hC,1,'h0);
        add(0,1,1,'hC,0,0,0, 0,0,1,'h0);
        add(0,1,0,0,0,0,0, 0,0,1,'h0);
        add(0,1,0,0,0,0,0, 0,0,1,'h0);
        add(0,1,0,0,1,0,0, 0,0,1,'h0);
        add(0,1,0,0,0,0,0, 1,'h10,1,'h4);
        add(0,1,1,'h10,0,0,0, 0,0,1,'h4);
        // Three outstanding plus a held request, jump to 0x100.
        add(1,0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,1,0,0, 1,'h0,0,0);
        add(0,1,0,0,1,0,0, 1,'h4,0,0);
        add(0,1,0,0,1,0,0, 1,'h8,0,0);
        add(0,0,0,0,1,1,'h100, 1,'hC,0,0);
        add(0,0,1,'h0,1,0,0, 1,'hC,0,0);
        add(0,1,1,'h4,1,0,0, 1,'hC,0,0);
        add(0,1,1,'h8,1,0,0, 1,'h100,0,0);
        add(0,0,1,'hC,1,0,0, 1,'h104,0,0);
        add(0,0,1,'h100,0,0,0, 1,'h104,0,0);
        add(0,0,0,0,0,0,0, 1,'h104,1,'h100);
        // Jump with instr and rdata handshakes in the same cycle.
        add(1,0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,0,0, 1,'h0,0,0);
        add(0,1,1,'h0,0,0,0, 1,'h4,0,0);
        add(0,0,1,'h4,1,1,'h40, 1,'h8,1,'h0);
        add(0,0,0,0,0,0,0, 1,'h8,0,0);
        add(0,1,0,0,0,0,0, 1,'h8,0,0);
        add(0,1,1,'h8,0,0,0, 1,'h40,0,0);
        add(0,0,1,'h40,0,0,0, 1,'h44,0,0);
        add(0,0,0,0,0,0,0, 1,'h44,1,'h40);

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.rst, v.ar, v.rv, v.rpc, v.ir, v.jmp, v.tgt);
            chk($sformatf("v%0d_av", i), bus.i_raddr_valid, v.av);
            chk($sformatf("v%0d_rrdy", i), bus.i_rdata_ready, !v.rst);
            if (v.av) chk($sformatf("v%0d_aa", i), bus.i_raddr, v.aa);
            chk($sformatf("v%0d_iv", i), bus.instr_valid, v.iv);
            if (v.iv) begin
                chk($sformatf("v%0d_ipc", i), bus.instr_pc, v.ipc);
                chk($sformatf("v%0d_word", i), bus.instr, word_at(v.ipc));
            end
        end

        // Held request at 0x8 across a jump to 0x200.
        drive(1,0,0,0,0,0,0);
        drive(0,1,0,0,0,0,0);
        chk("h_a0", bus.i_raddr, 'h0);
        drive(0,1,0,0,0,0,0);
        chk("h_a4", bus.i_raddr, 'h4);
        drive(0,0,0,0,0,0,0);
        chk("h_v8", bus.i_raddr_valid, 1);
        drive(0,0,0,0,0,1,'h200);
        chk("h_jmp8", bus.i_raddr, 'h8);
        drive(0,0,1,'h0,0,0,0);
        chk("h_hold1", bus.i_raddr, 'h8);
        drive(0,0,1,'h4,0,0,0);
        chk("h_hold2", bus.i_raddr, 'h8);
        drive(0,1,0,0,0,0,0);
        chk("h_acc_v", bus.i_raddr_valid, 1);
        chk("h_acc8", bus.i_raddr, 'h8);
        drive(0,0,1,'h8,0,0,0);
        chk("h_new_v", bus.i_raddr_valid, 1);
        chk("h_new", bus.i_raddr, 'h200);
        drive(0,1,0,0,0,0,0);
        chk("h_drop8", bus.instr_valid, 0);
        drive(0,0,1,'h200,0,0,0);
        chk("h_lat", bus.instr_valid, 0);
        drive(0,0,0,0,0,0,0);
        chk_instr("h_first", 'h200);

        // Reset with two requests outstanding; late data under reset.
        drive(1,0,0,0,0,0,0);
        drive(0,1,0,0,0,0,0);
        drive(0,1,0,0,0,0,0);
        chk("r_a4", bus.i_raddr, 'h4);
        for (int k = 0; k < 2; k++) begin
            drive(1,0,1,k*4,1,0,0);
            chk("r_av", bus.i_raddr_valid, 0);
            chk("r_rrdy", bus.i_rdata_ready, 0);
            chk("r_iv", bus.instr_valid, 0);
        end
        drive(0,0,0,0,0,0,0);
        chk("r_rel_v", bus.i_raddr_valid, 1);
        chk("r_rel_a", bus.i_raddr, RESET_VECTOR);
        chk("r_rel_iv", bus.instr_valid, 0);
        drive(0,0,0,0,0,0,0);
        chk("r_empty", bus.instr_valid, 0);
        drive(0,1,0,0,0,0,0);
        drive(0,0,1,'h0,0,0,0);
        chk("r_next", bus.i_raddr, 'h4);
        drive(0,0,0,0,0,0,0);
        chk_instr("r_first", RESET_VECTOR);

        // Random memory latency, back-pressure and redirects.
        drive(1,0,0,0,0,0,0);
        exp_pc = RESET_VECTOR;
        live = 0;
        consumed = 0;
        tb_stale = 0;
        held = 0;
        held_addr = '0;
        memq.delete();
        for (int c = 0; c < 4000; c++) begin
            ar  = $urandom_range(0, 3) != 0;
            rv  = memq.size() != 0 && $urandom_range(0, 2) != 0;
            ir  = $urandom_range(0, 2) != 0;
            jmp = $urandom_range(0, 40) == 0;
            tgt = 32'($urandom_range(0, 1023)) << 2;
            drive(0, ar, rv, rv ? memq[0] : 32'h0, ir, jmp, tgt);
            if (held) begin
                chk("rnd_hold_v", bus.i_raddr_valid, 1);
                chk("rnd_hold_a", bus.i_raddr, held_addr);
            end
            a_hs = bus.i_raddr_valid & ar;
            if (a_hs) begin
                memq.push_back(bus.i_raddr);
                if (!tb_stale) live++;
                tb_stale = 0;
                chk("rnd_credit", 32'(live <= DEPTH), 1);
            end
            if (rv) void'(memq.pop_front());
            if (bus.instr_valid && ir) begin
                chk("rnd_pc", bus.instr_pc, exp_pc);
                chk("rnd_word", bus.instr, word_at(exp_pc));
                exp_pc = exp_pc + INSTR_BYTES;
                live--;
                consumed++;
            end
            if (jmp) begin
                exp_pc = tgt;
                live = 0;
                if (bus.i_raddr_valid && !a_hs) tb_stale = 1;
            end
            held = bus.i_raddr_valid & !a_hs;
            held_addr = bus.i_raddr;
        end
        chk("rnd_progress", 32'(consumed > 200), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
